// File: rtl/serial_sub_if.sv
// Operand/result bundle for the bit-serial subtractor sequencer.
// The requester drives start and the operands; the sequencer returns busy/done and the result.
interface serial_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );
endinterface

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell stepped LSB-first,
// with the borrow carried between steps in a register.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   S_IDLE | waiting for start; diff/bout hold the last completed result
//   S_RUN  | one bit per clock through the cell; cnt = index of bit in work
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  serial_sub_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             accept;
  logic             last_bit;
  logic             cell_d;
  logic             cell_bo;

  // The shared 1-bit full-subtractor cell: d = a - b - c, bo = borrow out.
  assign cell_d  = a_sh[0] ^ b_sh[0] ^ brw;
  assign cell_bo = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & brw);

  // Next-state decode; start is only looked at while idle.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last_bit  = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (cnt == CNT_LAST) begin
          last_bit  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Operand capture, serial stepping and result publication.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      r_sh   <= '0;
      brw    <= 1'b0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else begin
      done_q <= last_bit;
      if (accept) begin
        a_sh   <= bus.a;
        b_sh   <= bus.b;
        brw    <= bus.bin;
        cnt    <= '0;
        busy_q <= 1'b1;
      end else if (state == S_RUN) begin
        r_sh <= {cell_d, r_sh[WIDTH-1:1]};
        brw  <= cell_bo;
        a_sh <= a_sh >> 1;
        b_sh <= b_sh >> 1;
        if (last_bit) begin
          // Counter parks at zero rather than running past the last bit.
          cnt    <= '0;
          diff_q <= {cell_d, r_sh[WIDTH-1:1]};
          bout_q <= cell_bo;
          busy_q <= 1'b0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Bench for serial_sub_ctrl: an 8-bit and a 2-bit instance checked against
// an arithmetic model of a - b - bin.
module tb_serial_sub_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_sub_if #(.WIDTH(8)) sif8 ();
  serial_sub_if #(.WIDTH(2)) sif2 ();

  serial_sub_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(sif8.slave));
  serial_sub_ctrl #(.WIDTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(sif2.slave));

  int passed = 0;
  int total  = 0;

  // Last published result per instance (index 0 = 8-bit, 1 = 2-bit) and the pending one.
  logic [31:0] last_diff [2];
  logic        last_bout [2];
  logic [31:0] pend_diff [2];
  logic        pend_bout [2];

  function automatic int wd(int sel);
    return (sel != 0) ? 2 : 8;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive(int sel, logic s, logic [31:0] a, logic [31:0] b, logic bin);
    if (sel == 0) begin
      sif8.start = s; sif8.a = a[7:0]; sif8.b = b[7:0]; sif8.bin = bin;
    end else begin
      sif2.start = s; sif2.a = a[1:0]; sif2.b = b[1:0]; sif2.bin = bin;
    end
  endtask

  function automatic logic [31:0] o_diff(int sel);
    return (sel != 0) ? 32'(sif2.diff) : 32'(sif8.diff);
  endfunction
  function automatic logic o_bout(int sel);
    return (sel != 0) ? sif2.bout : sif8.bout;
  endfunction
  function automatic logic o_busy(int sel);
    return (sel != 0) ? sif2.busy : sif8.busy;
  endfunction
  function automatic logic o_done(int sel);
    return (sel != 0) ? sif2.done : sif8.done;
  endfunction

  // Plain wide subtraction; a negative result shows up as bit WIDTH set.
  task automatic model(int sel, logic [31:0] a, logic [31:0] b, logic bin,
                       output logic [31:0] d, output logic bo);
    logic [32:0] mask;
    logic [32:0] r;
    mask = (33'd1 << wd(sel)) - 33'd1;
    r    = ({1'b0, a} & mask) - ({1'b0, b} & mask) - 33'(bin);
    d    = 32'(r & mask);
    bo   = r[wd(sel)];
  endtask

  // Present a request for one edge, then scramble the operands to prove they were latched.
  task automatic launch(int sel, logic [31:0] a, logic [31:0] b, logic bin);
    model(sel, a, b, bin, pend_diff[sel], pend_bout[sel]);
    drive(sel, 1'b1, a, b, bin);
    tick();
    drive(sel, 1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)));
    check("busy_after_start", 32'(o_busy(sel)), 32'd1);
    check("done_low_in_run", 32'(o_done(sel)), 32'd0);
  endtask

  // Wait (bounded) for done; results must not change before it. Optional start glitches while busy.
  task automatic wait_done(int sel, string tag, bit glitch);
    int n  = 0;
    int bc = 0;
    while (o_done(sel) !== 1'b1 && n < 40) begin
      if (o_busy(sel) === 1'b1) bc++;
      check({tag, "_hold_diff"}, o_diff(sel), last_diff[sel]);
      check({tag, "_hold_bout"}, 32'(o_bout(sel)), 32'(last_bout[sel]));
      if (glitch) drive(sel, (n == 2 || n == 4), 32'h0, 32'hFF, 1'b0);
      tick();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(wd(sel)));
    check({tag, "_busy_cycles"}, 32'(bc), 32'(wd(sel)));
    check({tag, "_done"}, 32'(o_done(sel)), 32'd1);
    check({tag, "_busy_low"}, 32'(o_busy(sel)), 32'd0);
    check({tag, "_diff"}, o_diff(sel), pend_diff[sel]);
    check({tag, "_bout"}, 32'(o_bout(sel)), 32'(pend_bout[sel]));
    last_diff[sel] = pend_diff[sel];
    last_bout[sel] = pend_bout[sel];
  endtask

  task automatic settle(int sel, int cycles);
    for (int i = 0; i < cycles; i++) begin
      tick();
      check("idle_done_low", 32'(o_done(sel)), 32'd0);
      check("idle_busy_low", 32'(o_busy(sel)), 32'd0);
      check("idle_hold_diff", o_diff(sel), last_diff[sel]);
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    for (int s = 0; s < 2; s++) begin
      last_diff[s] = '0; last_bout[s] = 1'b0;
      pend_diff[s] = '0; pend_bout[s] = 1'b0;
    end

    // Reset, with start asserted to show reset wins.
    rst_n = 1'b0;
    drive(0, 1'b1, 32'h5A, 32'h3C, 1'b0);
    drive(1, 1'b1, 32'h3, 32'h1, 1'b0);
    tick();
    tick();
    for (int s = 0; s < 2; s++) begin
      check("rst_busy", 32'(o_busy(s)), 32'd0);
      check("rst_done", 32'(o_done(s)), 32'd0);
      check("rst_diff", o_diff(s), 32'd0);
      check("rst_bout", 32'(o_bout(s)), 32'd0);
    end
    drive(0, 1'b0, 0, 0, 1'b0);
    drive(1, 1'b0, 0, 0, 1'b0);
    rst_n = 1'b1;
    tick();
    check("post_rst_idle", 32'(o_busy(0)), 32'd0);

    // Directed 8-bit cases.
    launch(0, 32'h5A, 32'h3C, 1'b0); wait_done(0, "t1", 1'b0); settle(0, 2);
    launch(0, 32'h00, 32'h01, 1'b0); wait_done(0, "t2a", 1'b0); settle(0, 1);
    launch(0, 32'h00, 32'h00, 1'b1); wait_done(0, "t2b", 1'b0); settle(0, 1);
    launch(0, 32'hFF, 32'hFF, 1'b0); wait_done(0, "t3a", 1'b0);
    launch(0, 32'h80, 32'h01, 1'b0); wait_done(0, "t3b", 1'b0); settle(0, 1);
    launch(0, 32'h10, 32'h01, 1'b0); wait_done(0, "t4", 1'b1); settle(0, 6);

    // Abort mid-run.
    launch(0, 32'hC3, 32'h2D, 1'b1);
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    check("abort_busy", 32'(o_busy(0)), 32'd0);
    check("abort_done", 32'(o_done(0)), 32'd0);
    check("abort_diff", o_diff(0), 32'd0);
    check("abort_bout", 32'(o_bout(0)), 32'd0);
    rst_n = 1'b1;
    for (int s = 0; s < 2; s++) begin
      last_diff[s] = '0; last_bout[s] = 1'b0;
    end
    settle(0, 12);
    launch(0, 32'hC3, 32'h2D, 1'b1); wait_done(0, "t5", 1'b0); settle(0, 1);

    // Randomized 8-bit operands, some issued back-to-back in the done cycle.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = (i % 6 == 0) ? ra : $urandom;
      launch(0, ra, rb, 1'($urandom_range(0, 1)));
      wait_done(0, "rnd", 1'b0);
      if ($urandom_range(0, 1) == 0) settle(0, 1);
    end
    settle(0, 1);

    // 2-bit instance, every operand combination.
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int c = 0; c < 2; c++) begin
          launch(1, 32'(a), 32'(b), 1'(c));
          wait_done(1, "w2", 1'b0);
          settle(1, 1);
        end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
